// File: rtl/regfile_mp.sv
//==============================================================================
// Module   : regfile_mp
// Brief    : Multi-port integer register file with write bypass, hardwired
//            zero register, write-conflict flag and per-register busy bits.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*XLEN-1:0]  rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*XLEN-1:0]  wdata,
    input  logic                 resv_en,
    input  logic [AW-1:0]        resv_addr,
    output logic                 wconflict,
    output logic [NREG-1:0]      busy_vec
);

    localparam bit c_zero   = (ZERO_REG != 0);
    localparam bit c_bypass = (BYPASS != 0);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;

    logic [NWR-1:0]  w_weff;
    logic [NREG-1:0] w_hit;
    logic [XLEN-1:0] w_hdata [NREG];
    logic            w_conf;

    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            w_weff[j] = wen[j] && (!c_zero || (waddr[j*AW +: AW] != '0));
        end
    end

    // Per-register write decode; later ports overwrite earlier ones so the
    // highest-index port wins when addresses collide.
    always_comb begin
        w_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            w_hdata[r] = '0;
            for (int j = 0; j < NWR; j++) begin
                if (w_weff[j] && (waddr[j*AW +: AW] == AW'(r))) begin
                    w_hit[r]   = 1'b1;
                    w_hdata[r] = wdata[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        w_conf = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            for (int k = j + 1; k < NWR; k++) begin
                if (w_weff[j] && w_weff[k] &&
                    (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
                    w_conf = 1'b1;
                end
            end
        end
    end

    assign wconflict = w_conf & ~rst;
    assign busy_vec  = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_hit[r]) begin
                    r_regs[r] <= w_hdata[r];
                end
            end
        end
    end

    // A reservation is the newer producer, so it beats a same-cycle writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (resv_en && (resv_addr == AW'(r)) && !(c_zero && (r == 0))) begin
                    r_busy[r] <= 1'b1;
                end else if (w_hit[r]) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        logic            w_rb;

        assign w_ra = raddr[i*AW +: AW];

        always_comb begin
            w_rd = r_regs[w_ra];
            w_rb = r_busy[w_ra];
            if (c_bypass && w_hit[w_ra]) begin
                w_rd = w_hdata[w_ra];
                w_rb = 1'b0;
            end
            if ((c_zero && (w_ra == '0)) || rst) begin
                w_rd = '0;
                w_rb = 1'b0;
            end
        end

        assign rdata[i*XLEN +: XLEN] = w_rd;
        assign rbusy[i]              = w_rb;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//==============================================================================
// Module   : tb_regfile_mp
// Brief    : Directed self-checking bench for regfile_mp (bypass and
//            non-bypass instances driven in parallel against a bench model).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NRD*AW-1:0]   raddr;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                resv_en;
    logic [AW-1:0]       resv_addr;

    logic [NRD*XLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic                wconf_b, wconf_n;
    logic [NREG-1:0]     bvec_b, bvec_n;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                 .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .resv_en(resv_en),
        .resv_addr(resv_addr), .wconflict(wconf_b), .busy_vec(bvec_b));

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR),
                 .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .wen(wen), .waddr(waddr), .wdata(wdata), .resv_en(resv_en),
        .resv_addr(resv_addr), .wconflict(wconf_n), .busy_vec(bvec_n));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: plain arrays updated once per clock.
    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];
    bit              chk_en = 1'b0;

    function automatic bit eff(input int j);
        return wen[j] && (waddr[j*AW +: AW] != '0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_regs[r] <= '0;
                m_busy[r] <= 1'b0;
            end
            chk_en <= 1'b1;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (eff(j)) begin
                    m_regs[waddr[j*AW +: AW]] <= wdata[j*XLEN +: XLEN];
                    m_busy[waddr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (resv_en && resv_addr != '0) m_busy[resv_addr] <= 1'b1;
        end
    end

    task automatic exp_read(input int i, input bit byp,
                            output logic [XLEN-1:0] d, output logic b);
        logic [AW-1:0] a;
        a = raddr[i*AW +: AW];
        d = m_regs[a];
        b = m_busy[a];
        if (byp) begin
            for (int j = 0; j < NWR; j++) begin
                if (eff(j) && waddr[j*AW +: AW] == a) begin
                    d = wdata[j*XLEN +: XLEN];
                    b = 1'b0;
                end
            end
        end
        if (rst || a == '0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    function automatic logic exp_conf();
        logic c = 1'b0;
        for (int j = 0; j < NWR; j++)
            for (int k = 0; k < NWR; k++)
                if (j != k && eff(j) && eff(k) && waddr[j*AW +: AW] == waddr[k*AW +: AW])
                    c = 1'b1;
        return c & ~rst;
    endfunction

    function automatic logic [NREG-1:0] exp_bvec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    always @(negedge clk) begin
        logic [XLEN-1:0] d;
        logic            b;
        if (chk_en) begin
            for (int i = 0; i < NRD; i++) begin
                exp_read(i, 1'b1, d, b);
                chk($sformatf("byp_rdata%0d", i), rdata_b[i*XLEN +: XLEN], d);
                chk($sformatf("byp_rbusy%0d", i), rbusy_b[i], b);
                exp_read(i, 1'b0, d, b);
                chk($sformatf("nb_rdata%0d", i), rdata_n[i*XLEN +: XLEN], d);
                chk($sformatf("nb_rbusy%0d", i), rbusy_n[i], b);
            end
            chk("byp_wconflict", wconf_b, exp_conf());
            chk("nb_wconflict",  wconf_n, exp_conf());
            chk("byp_busy_vec",  bvec_b,  exp_bvec());
            chk("nb_busy_vec",   bvec_n,  exp_bvec());
        end
    end

    task automatic idle();
        rst = 1'b0; wen = '0; waddr = '0; wdata = '0;
        resv_en = 1'b0; resv_addr = '0; raddr = '0;
    endtask

    task automatic wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wen[j] = 1'b1;
        waddr[j*AW +: AW] = a;
        wdata[j*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();

        // Reset then read
        idle(); rd(5'd0, 5'd1); settle();
        chk("t1_rdata0", rdata_b[31:0], 32'h0);
        chk("t1_rdata1", rdata_b[63:32], 32'h0);
        chk("t1_rbusy", rbusy_b, 2'b00);
        chk("t1_busy_vec", bvec_b, 32'h0);
        tick();

        // Write and read back, with and without bypass
        idle(); wr(0, 5'd1, 32'hdeadbeef); rd(5'd1, 5'd0); settle();
        chk("t2_byp_same", rdata_b[31:0], 32'hdeadbeef);
        chk("t2_nb_same", rdata_n[31:0], 32'h0);
        tick();
        idle(); rd(5'd1, 5'd1); settle();
        chk("t2_byp_after", rdata_b[31:0], 32'hdeadbeef);
        chk("t2_nb_after", rdata_n[63:32], 32'hdeadbeef);
        tick();

        // Zero register ignores writes and reservations
        idle(); wr(0, 5'd0, 32'hb105f00d); resv_en = 1'b1; resv_addr = 5'd0;
        rd(5'd0, 5'd0); settle();
        chk("t3_rdata_x0", rdata_b[31:0], 32'h0);
        chk("t3_wconflict", wconf_b, 1'b0);
        tick();
        idle(); settle();
        chk("t3_busy0", bvec_b[0], 1'b0);
        chk("t3_rdata_x0_after", rdata_n[31:0], 32'h0);
        tick();

        // Dual write to the same register: highest port wins
        idle(); wr(0, 5'd2, 32'h8badf00d); wr(1, 5'd2, 32'hbaadcafe); rd(5'd2, 5'd1); settle();
        chk("t4_wconflict", wconf_b, 1'b1);
        chk("t4_byp_rdata", rdata_b[31:0], 32'hbaadcafe);
        tick();
        idle(); rd(5'd2, 5'd2); settle();
        chk("t4_x2_after", rdata_n[31:0], 32'hbaadcafe);
        tick();
        idle(); wr(0, 5'd2, 32'h11111111); wr(1, 5'd3, 32'h22222222); settle();
        chk("t4_no_conflict", wconf_b, 1'b0);
        tick();
        idle(); rd(5'd2, 5'd3); settle();
        chk("t4_x2", rdata_b[31:0], 32'h11111111);
        chk("t4_x3", rdata_b[63:32], 32'h22222222);
        tick();

        // Scoreboard
        idle(); resv_en = 1'b1; resv_addr = 5'd3; tick();
        idle(); rd(5'd3, 5'd0); settle();
        chk("t5_rbusy_x3", rbusy_b[0], 1'b1);
        chk("t5_busy_vec", bvec_b, 32'h8);
        tick();
        idle(); wr(0, 5'd3, 32'hcafed00d); rd(5'd3, 5'd0); settle();
        chk("t5_byp_rbusy", rbusy_b[0], 1'b0);
        chk("t5_byp_rdata", rdata_b[31:0], 32'hcafed00d);
        chk("t5_nb_rbusy", rbusy_n[0], 1'b1);
        tick();
        idle(); rd(5'd3, 5'd0); settle();
        chk("t5_busy_cleared", bvec_b, 32'h0);
        chk("t5_x3", rdata_n[31:0], 32'hcafed00d);
        tick();
        idle(); wr(1, 5'd3, 32'h12345678); resv_en = 1'b1; resv_addr = 5'd3; tick();
        idle(); rd(5'd3, 5'd0); settle();
        chk("t5_resv_wins", bvec_b, 32'h8);
        chk("t5_x3_new", rdata_b[31:0], 32'h12345678);
        tick();

        // Reset mid-operation
        idle(); resv_en = 1'b1; resv_addr = 5'd5; tick();
        idle(); settle();
        chk("t6_busy_pre", bvec_b, 32'h28);
        tick();
        idle(); rst = 1'b1; wr(0, 5'd4, 32'haaaa5555); wr(1, 5'd4, 32'h5555aaaa); rd(5'd1, 5'd4); settle();
        chk("t6_rst_rdata", rdata_b[31:0], 32'h0);
        chk("t6_rst_rbusy", rbusy_b, 2'b00);
        chk("t6_rst_wconflict", wconf_b, 1'b0);
        tick();
        idle(); rd(5'd1, 5'd2); settle();
        chk("t6_x1", rdata_b[31:0], 32'h0);
        chk("t6_x2", rdata_b[63:32], 32'h0);
        chk("t6_busy_vec", bvec_b, 32'h0);
        tick();
        idle(); rd(5'd3, 5'd4); settle();
        chk("t6_x3", rdata_n[31:0], 32'h0);
        chk("t6_x4", rdata_n[63:32], 32'h0);
        tick();

        // Mixed traffic, checked against the model only
        for (int k = 1; k <= 8; k++) begin
            idle();
            wr(0, AW'(k + 8), 32'h11111111 * k);
            wr(1, AW'(k + 16), ~(32'h01010101 * k));
            resv_en = k[0];
            resv_addr = AW'(k + 15);
            rd(AW'(k + 8), AW'(k + 15));
            tick();
        end
        idle(); rd(5'd12, 5'd17); settle();
        chk("t7_x12", rdata_b[31:0], 32'h44444444);
        chk("t7_x17", rdata_b[63:32], 32'hfefefefe);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with a per-register busy scoreboard. It succeeds the single-write, two-read regfile in the core's decode/writeback path. It adds configurable read and write port counts, same-cycle write-to-read bypass, a hardwired zero register, write-conflict detection, and reservation tracking so issue logic can stall on pending writebacks.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports
BYPASS, 1, 1 = forward same-cycle write data to read ports; 0 = reads see stored value only
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and reservations
(derived) AW = $clog2(NREG)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
raddr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rbusy  out  NRD  busy bit of register addressed by read port i
wen  in  NWR  write enables
waddr  in  NWR*AW  write addresses
wdata  in  NWR*XLEN  write data
resv_en  in  1  reserve (mark busy) register resv_addr
resv_addr  in  AW  register to reserve
wconflict  out  1  two or more enabled write ports target the same effective register this cycle
busy_vec  out  NREG  current scoreboard, bit r = register r pending

Behaviour:
- Storage: NREG x XLEN flops plus NREG busy flops. Reset (rst=1 at an edge) clears all registers and busy bits to 0. Writes and reservations presented in a reset cycle are discarded.
- While rst=1: rdata=0, rbusy=0 and wconflict=0 (combinationally forced). busy_vec reflects the flops and is 0 from the first edge with rst high.
- Effective write: port j is effective when wen[j]=1, and also waddr[j]!=0 when ZERO_REG=1.
- Write: each effective port updates its register at the edge. When several effective ports share an address, the highest-index port wins. wconflict=1 in that cycle, combinationally. wconflict is diagnostic only; the write still occurs.
- Read: combinational, zero latency.
  - ZERO_REG=1 and raddr=0: rdata=0 and rbusy=0.
  - Otherwise, if BYPASS=1 and an effective write targets raddr this cycle: rdata = the winning port's wdata (highest index), and rbusy = 0.
  - Otherwise rdata = stored value and rbusy = busy[raddr].
- Scoreboard update at each edge, per register r:
  - If resv_en and resv_addr==r: busy[r] <= 1. A reservation takes precedence over a same-cycle write to r, because it is a newer producer.
  - Else if any effective write targets r: busy[r] <= 0.
  - Else busy[r] holds.
  - Reservation of register 0 is ignored when ZERO_REG=1.
- A write to a non-busy register is legal and leaves busy at 0.
- Address width wrap: when NREG is not fully addressed, out-of-range addresses cannot occur because NREG is a power of two.
- No internal pipelining. All outputs depend only on current inputs and current state.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, then raddr0=0, raddr1=1 -> rdata=0/0, rbusy=0/0, busy_vec=0.
2. Write and read back: port0 writes 0xdeadbeef to x1. In the same cycle raddr0=1 -> rdata0=0xdeadbeef via bypass. Next cycle (wen=0) -> still 0xdeadbeef. Repeat with BYPASS=0 -> old value 0 in the write cycle and 0xdeadbeef after.
3. Zero register: write 0xb105f00d to x0 with resv_en on x0 -> rdata for x0=0, busy_vec[0]=0, wconflict=0.
4. Dual-write conflict: port0 writes 0x8badf00d and port1 writes 0xbaadcafe, both to x2 -> wconflict=1, bypass rdata=0xbaadcafe, and after the edge x2=0xbaadcafe. Different addresses (x2, x3) -> both written, wconflict=0.
5. Scoreboard: reserve x3 -> next cycle rbusy=1 for raddr=3. Write 0xcafed00d to x3 -> same cycle rbusy=0 with rdata=0xcafed00d (BYPASS=1), and after the edge busy_vec[3]=0. Reserve and write x3 in the same cycle -> busy_vec[3]=1 after the edge.
6. Reset mid-operation: with x1..x3 loaded and x5 busy, assert rst for one cycle while wen=1 on x4 -> x1..x4 read 0 and busy_vec=0 afterwards.
